// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a byte-addressed data memory.
// Validates each request, performs one memory access cycle and returns a registered response.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic [1:0]       resp_fault,
  output logic [2:0]       mem_choose,
  output logic             mem_read,
  output logic             mem_write,
  output logic [5:0]       mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt,
  output logic [CNT_W-1:0] flt_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;
  localparam logic [1:0] StFault  = 2'd3;

  localparam logic [1:0] FltNone  = 2'b00;
  localparam logic [1:0] FltAlign = 2'b01;
  localparam logic [1:0] FltRange = 2'b10;
  localparam logic [1:0] FltFunct = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [5:0]       addr_q;
  logic [31:0]      wdata_q;
  logic [1:0]       fault_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] ld_cnt_q, st_cnt_q, flt_cnt_q;

  logic [2:0]       size;
  logic             legal;
  logic [32:0]      end_addr;
  logic [1:0]       code;

  // Classify the incoming request; funct3 legality outranks alignment, which outranks range.
  always_comb begin
    size  = 3'd1;
    legal = 1'b1;
    unique case (req_funct3)
      3'b000:  size = 3'd1;
      3'b001:  size = 3'd2;
      3'b010:  size = 3'd4;
      3'b100: begin
        size  = 3'd1;
        legal = ~req_we;
      end
      3'b101: begin
        size  = 3'd2;
        legal = ~req_we;
      end
      default: legal = 1'b0;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    end_addr = {1'b0, req_addr} + 33'(size);
    if (!legal) begin
      code = FltFunct;
    end else if ((size == 3'd2 && req_addr[0]) || (size == 3'd4 && req_addr[1:0] != 2'b00)) begin
      code = FltAlign;
    end else if (end_addr > 33'(MEM_BYTES)) begin
      code = FltRange;
    end else begin
      code = FltNone;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = (code == FltNone) ? StAccess : StFault;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      StFault:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 6'd0;
      wdata_q   <= 32'd0;
      fault_q   <= FltNone;
      rdata_q   <= 32'd0;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      flt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[5:0];
            wdata_q  <= req_wdata;
            fault_q  <= code;
            if (code != FltNone) rdata_q <= 32'd0;
          end
        end
        StAccess: rdata_q <= we_q ? 32'd0 : mem_rdata;
        StResp: begin
          if (we_q) begin
            if (st_cnt_q != '1) st_cnt_q <= st_cnt_q + CNT_W'(1);
          end else begin
            if (ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + CNT_W'(1);
          end
        end
        StFault: if (flt_cnt_q != '1) flt_cnt_q <= flt_cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp) || (state_q == StFault);
    resp_fault = (state_q == StFault) ? fault_q : FltNone;
    resp_rdata = rdata_q;
    mem_read   = (state_q == StAccess) && !we_q;
    mem_write  = (state_q == StAccess) && we_q;
    mem_choose = funct3_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    ld_cnt     = ld_cnt_q;
    st_cnt     = st_cnt_q;
    flt_cnt    = flt_cnt_q;
  end

endmodule
